ace_ccu_snoop_responder: RTL and testbench

//  Cached-master end of the ACE snoop channels: accepts AC snoops, runs a one-cycle lookup on the local tag

---
 rtl/ace_ccu_snoop_responder.sv | 214 +++++++++++++++++++++
 tb/tb_ace_ccu_snoop_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ace_ccu_snoop_responder.sv
// rtl/ace_ccu_snoop_responder.sv - ACE snoop-channel responder for a cached master
// Purpose: accepts AC snoops, does a one-cycle tag lookup, answers on CR,
// streams the line on CD when data is transferred, then updates the line state.
// Ports:
//   clk_i, rst_ni                         clock, async active-low reset
//   ac_valid_i/ac_ready_o/ac_addr_i/ac_snoop_i   snoop request channel
//   cr_valid_o/cr_ready_i/cr_resp_o       snoop response {WU,IS,PD,Err,DT}
//   cd_valid_o/cd_ready_i/cd_data_o/cd_last_o    snoop data channel
//   lu_req_o/lu_addr_o/lu_hit_i/lu_unique_i/lu_dirty_i   tag lookup port
//   rd_req_o/rd_beat_o/rd_data_i          line data read port
//   upd_valid_o/upd_addr_o/upd_inval_o/upd_unique_o      line state update
module ace_ccu_snoop_responder #(
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64,
    parameter int LineBytes = 64,
    localparam int Beats = (LineBytes * 8) / DataWidth,
    localparam int BeatW = (Beats > 1) ? $clog2(Beats) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ac_valid_i,
    output logic                 ac_ready_o,
    input  logic [AddrWidth-1:0] ac_addr_i,
    input  logic [3:0]           ac_snoop_i,
    output logic                 cr_valid_o,
    input  logic                 cr_ready_i,
    output logic [4:0]           cr_resp_o,
    output logic                 cd_valid_o,
    input  logic                 cd_ready_i,
    output logic [DataWidth-1:0] cd_data_o,
    output logic                 cd_last_o,
    output logic                 lu_req_o,
    output logic [AddrWidth-1:0] lu_addr_o,
    input  logic                 lu_hit_i,
    input  logic                 lu_unique_i,
    input  logic                 lu_dirty_i,
    output logic                 rd_req_o,
    output logic [BeatW-1:0]     rd_beat_o,
    input  logic [DataWidth-1:0] rd_data_i,
    output logic                 upd_valid_o,
    output logic [AddrWidth-1:0] upd_addr_o,
    output logic                 upd_inval_o,
    output logic                 upd_unique_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_DECIDE, S_CR, S_RD, S_CD, S_UPD
    } state_e;

    localparam logic [AddrWidth-1:0] OffMask  = AddrWidth'(LineBytes - 1);
    localparam logic [BeatW-1:0]     LastBeat = BeatW'(Beats - 1);

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [3:0]           snoop_q, snoop_d;
    logic [4:0]           resp_q, resp_d;
    logic                 need_data_q, need_data_d;
    logic                 need_upd_q, need_upd_d;
    logic                 inval_q, inval_d;
    logic                 unique_q, unique_d;
    logic [BeatW-1:0]     beat_q, beat_d;
    logic [DataWidth-1:0] data_q, data_d;
    logic                 held_q, held_d;

    logic dec_known, dec_dt, dec_is, dec_pd, dec_upd, dec_inval, dec_unique;
    logic is_last;

    // Response/update decode from the snoop type and the lookup result.
    always_comb begin
        dec_known  = 1'b0;
        dec_dt     = 1'b0;
        dec_is     = 1'b0;
        dec_pd     = 1'b0;
        dec_upd    = 1'b0;
        dec_inval  = 1'b0;
        dec_unique = 1'b0;
        if (lu_hit_i) begin
            case (snoop_q)
                4'b0000: begin
                    dec_known = 1'b1; dec_dt = 1'b1; dec_is = 1'b1;
                end
                4'b0001, 4'b0010, 4'b0011: begin
                    dec_known = 1'b1; dec_dt = 1'b1; dec_is = 1'b1;
                    dec_pd = lu_dirty_i; dec_upd = 1'b1;
                end
                4'b0111: begin
                    dec_known = 1'b1; dec_dt = 1'b1; dec_pd = lu_dirty_i;
                    dec_upd = 1'b1; dec_inval = 1'b1;
                end
                4'b1000: begin
                    // Clean-only: data and update are needed only for a dirty line.
                    dec_known = 1'b1; dec_dt = lu_dirty_i; dec_is = 1'b1;
                    dec_pd = lu_dirty_i; dec_upd = lu_dirty_i; dec_unique = lu_unique_i;
                end
                4'b1001: begin
                    dec_known = 1'b1; dec_dt = lu_dirty_i; dec_pd = lu_dirty_i;
                    dec_upd = 1'b1; dec_inval = 1'b1;
                end
                4'b1101: begin
                    dec_known = 1'b1; dec_upd = 1'b1; dec_inval = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign is_last = (beat_q == LastBeat);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        snoop_d     = snoop_q;
        resp_d      = resp_q;
        need_data_d = need_data_q;
        need_upd_d  = need_upd_q;
        inval_d     = inval_q;
        unique_d    = unique_q;
        beat_d      = beat_q;
        data_d      = data_q;
        held_d      = held_q;
        case (state_q)
            S_IDLE: begin
                if (ac_valid_i) begin
                    addr_d  = ac_addr_i & ~OffMask;
                    snoop_d = ac_snoop_i;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: state_d = S_DECIDE;
            S_DECIDE: begin
                resp_d      = {dec_known & lu_unique_i, dec_is, dec_pd, 1'b0, dec_dt};
                need_data_d = dec_dt;
                need_upd_d  = dec_upd;
                inval_d     = dec_inval;
                unique_d    = dec_unique;
                beat_d      = '0;
                state_d     = S_CR;
            end
            S_CR: begin
                if (cr_ready_i) begin
                    if (need_data_q)     state_d = S_RD;
                    else if (need_upd_q) state_d = S_UPD;
                    else                 state_d = S_IDLE;
                end
            end
            S_RD: begin
                held_d  = 1'b0;
                state_d = S_CD;
            end
            S_CD: begin
                // Read data is only valid in the first CD cycle; hold it after that.
                if (!held_q) begin
                    data_d = rd_data_i;
                    held_d = 1'b1;
                end
                if (cd_ready_i) begin
                    if (is_last) begin
                        beat_d  = '0;
                        state_d = need_upd_q ? S_UPD : S_IDLE;
                    end else begin
                        beat_d  = beat_q + BeatW'(1);
                        state_d = S_RD;
                    end
                end
            end
            S_UPD:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            snoop_q     <= '0;
            resp_q      <= '0;
            need_data_q <= 1'b0;
            need_upd_q  <= 1'b0;
            inval_q     <= 1'b0;
            unique_q    <= 1'b0;
            beat_q      <= '0;
            data_q      <= '0;
            held_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            snoop_q     <= snoop_d;
            resp_q      <= resp_d;
            need_data_q <= need_data_d;
            need_upd_q  <= need_upd_d;
            inval_q     <= inval_d;
            unique_q    <= unique_d;
            beat_q      <= beat_d;
            data_q      <= data_d;
            held_q      <= held_d;
        end
    end

    assign ac_ready_o   = (state_q == S_IDLE);
    assign lu_req_o     = (state_q == S_LOOKUP);
    assign lu_addr_o    = addr_q;
    assign cr_valid_o   = (state_q == S_CR);
    assign cr_resp_o    = resp_q;
    assign rd_req_o     = (state_q == S_RD);
    assign rd_beat_o    = beat_q;
    assign cd_valid_o   = (state_q == S_CD);
    assign cd_data_o    = held_q ? data_q : rd_data_i;
    assign cd_last_o    = (state_q == S_CD) && is_last;
    assign upd_valid_o  = (state_q == S_UPD);
    assign upd_addr_o   = addr_q;
    assign upd_inval_o  = inval_q;
    assign upd_unique_o = unique_q;

endmodule

// File: tb/tb_ace_ccu_snoop_responder.sv
// tb/tb_ace_ccu_snoop_responder.sv - self-checking bench for ace_ccu_snoop_responder
module tb_ace_ccu_snoop_responder;
    localparam int NB = 8;
    localparam int LB = 64;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        ac_valid_i, ac_ready_o;
    logic [63:0] ac_addr_i;
    logic [3:0]  ac_snoop_i;
    logic        cr_valid_o, cr_ready_i;
    logic [4:0]  cr_resp_o;
    logic        cd_valid_o, cd_ready_i, cd_last_o;
    logic [63:0] cd_data_o;
    logic        lu_req_o, lu_hit_i, lu_unique_i, lu_dirty_i;
    logic [63:0] lu_addr_o;
    logic        rd_req_o;
    logic [2:0]  rd_beat_o;
    logic [63:0] rd_data_i;
    logic        upd_valid_o, upd_inval_o, upd_unique_o;
    logic [63:0] upd_addr_o;

    ace_ccu_snoop_responder dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .ac_valid_i(ac_valid_i), .ac_ready_o(ac_ready_o), .ac_addr_i(ac_addr_i), .ac_snoop_i(ac_snoop_i),
        .cr_valid_o(cr_valid_o), .cr_ready_i(cr_ready_i), .cr_resp_o(cr_resp_o),
        .cd_valid_o(cd_valid_o), .cd_ready_i(cd_ready_i), .cd_data_o(cd_data_o), .cd_last_o(cd_last_o),
        .lu_req_o(lu_req_o), .lu_addr_o(lu_addr_o), .lu_hit_i(lu_hit_i), .lu_unique_i(lu_unique_i),
        .lu_dirty_i(lu_dirty_i), .rd_req_o(rd_req_o), .rd_beat_o(rd_beat_o), .rd_data_i(rd_data_i),
        .upd_valid_o(upd_valid_o), .upd_addr_o(upd_addr_o), .upd_inval_o(upd_inval_o),
        .upd_unique_o(upd_unique_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Snoop table: response and resulting line-state action for one snoop.
    function automatic void model(input logic [3:0] t, input logic h, u, d,
                                  output logic [4:0] r, output logic dt, up, inv, un);
        logic wu, is, pd;
        logic known;
        known = 1'b1; dt = 0; is = 0; pd = 0; up = 0; inv = 0; un = 0;
        if (!h) known = 1'b0;
        else if (t == 4'd0) begin dt = 1; is = 1; end
        else if (t >= 4'd1 && t <= 4'd3) begin dt = 1; is = 1; pd = d; up = 1; end
        else if (t == 4'd7) begin dt = 1; pd = d; up = 1; inv = 1; end
        else if (t == 4'd8) begin dt = d; is = 1; pd = d; up = d; un = u; end
        else if (t == 4'd9) begin dt = d; pd = d; up = 1; inv = 1; end
        else if (t == 4'd13) begin up = 1; inv = 1; end
        else known = 1'b0;
        if (!known) begin dt = 0; is = 0; pd = 0; up = 0; inv = 0; end
        wu = known & u;
        r  = {wu, is, pd, 1'b0, dt};
    endfunction

    // Responder-side stimulus and observations
    logic        pend_hit = 0, pend_u = 0, pend_d = 0;
    logic [63:0] line_base = 0;
    int          lu_age = 2, rd_age = 2;
    int          hs_cyc, idle_cyc, lu_cyc, lu_cnt, cr_first, cr_hs, cr_unstable;
    int          cd_unstable, cd_early, upd_cnt, upd_beats;
    logic [4:0]  cr_obs, cr_prev;
    logic [63:0] lu_addr_obs, cd_prev_data, upd_addr_obs;
    logic        cr_wait = 0, cd_wait = 0, cd_prev_last, upd_inval_obs, upd_unique_obs;
    logic [63:0] beat_data[$];
    logic        beat_last[$];
    int          cr_pct = 100, cd_pct = 100, cr_min_wait = 0, cr_wait_cnt = 0;
    bit          cd_toggle = 0;

    always @(negedge clk) begin
        if (rst_ni) begin
            if (ac_valid_i && ac_ready_o) hs_cyc = cyc;
            if (ac_ready_o && hs_cyc >= 0 && cyc > hs_cyc && idle_cyc < 0) idle_cyc = cyc;
            if (lu_req_o) begin lu_cnt++; lu_cyc = cyc; lu_addr_obs = lu_addr_o; end
            if (cr_wait && (!cr_valid_o || cr_resp_o !== cr_prev)) cr_unstable++;
            cr_wait = 0;
            if (cr_valid_o) begin
                if (cr_first < 0) cr_first = cyc;
                if (cr_ready_i) begin cr_hs++; cr_obs = cr_resp_o; end
                else begin cr_wait = 1; cr_prev = cr_resp_o; end
            end
            if (cd_wait && (!cd_valid_o || cd_data_o !== cd_prev_data || cd_last_o !== cd_prev_last))
                cd_unstable++;
            cd_wait = 0;
            if (cd_valid_o) begin
                if (cr_hs == 0) cd_early++;
                if (cd_ready_i) begin
                    beat_data.push_back(cd_data_o);
                    beat_last.push_back(cd_last_o);
                end else begin
                    cd_wait = 1; cd_prev_data = cd_data_o; cd_prev_last = cd_last_o;
                end
            end
            if (upd_valid_o) begin
                upd_cnt++; upd_inval_obs = upd_inval_o; upd_unique_obs = upd_unique_o;
                upd_addr_obs = upd_addr_o; upd_beats = beat_data.size();
            end
        end
        // Tag array model: answer valid for the whole cycle after the strobe, garbage otherwise.
        if (lu_req_o) begin
            lu_hit_i = pend_hit; lu_unique_i = pend_u; lu_dirty_i = pend_d; lu_age = 0;
        end else if (lu_age == 0) lu_age = 1;
        else begin
            lu_hit_i = 1'($urandom); lu_unique_i = 1'($urandom); lu_dirty_i = 1'($urandom);
        end
        // Data array model: word = line_base + beat, valid only the cycle after rd_req_o.
        if (rd_req_o) begin
            rd_data_i = line_base + 64'(rd_beat_o); rd_age = 0;
        end else if (rd_age == 0) rd_age = 1;
        else rd_data_i = {$urandom, $urandom};
    end

    initial begin
        cr_ready_i = 0;
        cd_ready_i = 0;
        forever begin
            @(posedge clk); #1;
            if (cr_valid_o && cr_wait_cnt < cr_min_wait) begin
                cr_ready_i = 0; cr_wait_cnt++;
            end else cr_ready_i = ($urandom_range(99) < cr_pct);
            if (cd_toggle) cd_ready_i = ~cd_ready_i;
            else cd_ready_i = ($urandom_range(99) < cd_pct);
        end
    end

    task automatic issue(input logic [3:0] t, input logic [63:0] addr, input logic h, u, d,
                         input logic [63:0] base);
        bit ok;
        pend_hit = h; pend_u = u; pend_d = d; line_base = base;
        hs_cyc = -1; idle_cyc = -1; lu_cyc = -1; lu_cnt = 0; cr_first = -1; cr_hs = 0;
        cr_unstable = 0; cd_unstable = 0; cd_early = 0; upd_cnt = 0; upd_beats = -1;
        cr_wait = 0; cd_wait = 0; cr_wait_cnt = 0; cr_obs = '1;
        beat_data.delete(); beat_last.delete();
        @(posedge clk); #1;
        ac_valid_i = 1; ac_addr_i = addr; ac_snoop_i = t;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ac_ready_o) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        ac_valid_i = 0; ac_addr_i = {$urandom, $urandom}; ac_snoop_i = 4'($urandom);
        chk("ac_handshake", 64'(ok), 1);
    endtask

    task automatic run_snoop(input logic [3:0] t, input logic [63:0] addr, input logic h, u, d,
                             input logic [63:0] base, input bit chk_idle);
        logic [4:0]  er;
        logic        edt, eup, einv, eun;
        logic [63:0] al;
        bit          ok;
        model(t, h, u, d, er, edt, eup, einv, eun);
        al = addr & ~64'(LB - 1);
        issue(t, addr, h, u, d, base);
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (cr_hs > 0 && ac_ready_o) begin ok = 1; break; end
        end
        chk("snoop_done", 64'(ok), 1);
        chk("lu_latency", 64'(lu_cyc - hs_cyc), 1);
        chk("lu_count", 64'(lu_cnt), 1);
        chk("lu_addr", lu_addr_obs, al);
        chk("cr_latency", 64'(cr_first - hs_cyc), 3);
        chk("cr_resp", 64'(cr_obs), 64'(er));
        chk("cr_count", 64'(cr_hs), 1);
        chk("cr_stable", 64'(cr_unstable), 0);
        chk("cd_beats", 64'(beat_data.size()), edt ? 64'(NB) : 64'(0));
        for (int b = 0; b < beat_data.size(); b++) begin
            chk("cd_data", beat_data[b], base + 64'(b));
            chk("cd_last", 64'(beat_last[b]), 64'(b == NB - 1));
        end
        chk("cd_stable", 64'(cd_unstable), 0);
        chk("cd_before_cr", 64'(cd_early), 0);
        chk("upd_count", 64'(upd_cnt), 64'(eup));
        if (eup) begin
            chk("upd_inval", 64'(upd_inval_obs), 64'(einv));
            if (!einv) chk("upd_unique", 64'(upd_unique_obs), 64'(eun));
            chk("upd_addr", upd_addr_obs, al);
            chk("upd_after_data", 64'(upd_beats), 64'(beat_data.size()));
        end
        if (chk_idle) chk("idle_latency", 64'(idle_cyc - hs_cyc), 4);
    endtask

    initial begin
        logic [3:0]  codes [0:8];
        logic [3:0]  t;
        bit          ok;
        codes = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd8, 4'd9, 4'd13, 4'd4};
        rst_ni = 0; ac_valid_i = 0; ac_addr_i = 0; ac_snoop_i = 0;
        lu_hit_i = 0; lu_unique_i = 0; lu_dirty_i = 0; rd_data_i = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ac_ready", 64'(ac_ready_o), 1);
        chk("rst_cr_valid", 64'(cr_valid_o), 0);
        chk("rst_cd_valid", 64'(cd_valid_o), 0);
        chk("rst_upd_valid", 64'(upd_valid_o), 0);
        chk("rst_lu_req", 64'(lu_req_o), 0);
        chk("rst_rd_req", 64'(rd_req_o), 0);
        chk("rst_cr_resp", 64'(cr_resp_o), 0);
        @(negedge clk); #1 rst_ni = 1;

        run_snoop(4'b0001, {$urandom, $urandom}, 0, 0, 0, 64'h100, 1);      // miss
        run_snoop(4'b0111, 64'h0000_1000_0000_0040, 1, 1, 1, 64'h0, 0);    // ReadUnique U D
        run_snoop(4'b1000, {$urandom, $urandom}, 1, 1, 0, 64'h200, 0);      // CleanShared clean
        run_snoop(4'b1000, {$urandom, $urandom}, 1, 1, 1, 64'h300, 0);      // CleanShared dirty
        cr_min_wait = 5; cd_toggle = 1;
        run_snoop(4'b0111, {$urandom, $urandom}, 1, 0, 1, 64'h400, 0);      // backpressure
        cr_min_wait = 0; cd_toggle = 0;
        run_snoop(4'b0000, {$urandom, $urandom}, 1, 0, 1, 64'h500, 0);      // ReadOnce
        run_snoop(4'b0100, {$urandom, $urandom}, 1, 1, 1, 64'h600, 0);      // unknown code

        // Reset in the middle of beat 3
        cd_pct = 50;
        issue(4'b0111, {$urandom, $urandom}, 1, 1, 1, 64'h700);
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            if (beat_data.size() == 3 && cd_valid_o) begin ok = 1; break; end
        end
        chk("reach_beat3", 64'(ok), 1);
        #2 rst_ni = 0;
        #1;
        chk("mid_rst_cd_valid", 64'(cd_valid_o), 0);
        chk("mid_rst_cr_valid", 64'(cr_valid_o), 0);
        chk("mid_rst_upd_valid", 64'(upd_valid_o), 0);
        chk("mid_rst_rd_req", 64'(rd_req_o), 0);
        chk("mid_rst_ac_ready", 64'(ac_ready_o), 1);
        @(negedge clk); #1 rst_ni = 1;
        upd_cnt = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("post_rst_no_upd", 64'(upd_cnt), 0);
        chk("post_rst_ac_ready", 64'(ac_ready_o), 1);
        cd_pct = 100;
        run_snoop(4'b0010, {$urandom, $urandom}, 1, 1, 1, 64'h800, 0);

        // Randomized snoops
        for (int n = 0; n < 60; n++) begin
            cr_pct = $urandom_range(100, 30);
            cd_pct = $urandom_range(100, 30);
            t = ($urandom_range(3) == 0) ? 4'($urandom) : codes[$urandom_range(8)];
            run_snoop(t, {$urandom, $urandom}, 1'($urandom_range(3) != 0), 1'($urandom),
                      1'($urandom), {$urandom, $urandom}, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
